// File: rtl/truth_table_sweeper.sv
// Self-test driver/reader: walks all 16 {w,x,y,z} vectors into an external function,
// captures its response into a truth table and scores it against EXPECTED.
module truth_table_sweeper #(
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [15:0] EXPECTED      = 16'h0000
) (
    input  logic        CL2947MP_clk,
    input  logic        CL2947MP_reset,
    input  logic        CL2947MP_start,
    input  logic        CL2947MP_f_in,
    output logic        CL2947MP_w,
    output logic        CL2947MP_x,
    output logic        CL2947MP_y,
    output logic        CL2947MP_z,
    output logic        CL2947MP_busy,
    output logic        CL2947MP_done,
    output logic [15:0] CL2947MP_table,
    output logic        CL2947MP_match,
    output logic [4:0]  CL2947MP_mismatch
);
    localparam int             CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

    state_t        state, state_n;
    logic [3:0]    idx, idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [15:0]   tbl, tbl_n;
    logic [4:0]    mis, mis_n;
    logic          match_q, match_n;
    logic [3:0]    vec_q, vec_n;

    always_ff @(posedge CL2947MP_clk) begin
        if (CL2947MP_reset) begin
            state   <= IDLE;
            idx     <= 4'd0;
            cnt     <= '0;
            tbl     <= 16'h0000;
            mis     <= 5'd0;
            match_q <= 1'b0;
            vec_q   <= 4'b0000;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            cnt     <= cnt_n;
            tbl     <= tbl_n;
            mis     <= mis_n;
            match_q <= match_n;
            vec_q   <= vec_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        tbl_n   = tbl;
        mis_n   = mis;
        match_n = match_q;
        case (state)
            IDLE: begin
                if (CL2947MP_start) begin
                    state_n = APPLY;
                    idx_n   = 4'd0;
                    cnt_n   = '0;
                    tbl_n   = 16'h0000;
                    mis_n   = 5'd0;
                    match_n = 1'b0;
                end
            end
            APPLY: begin
                if (cnt == CNT_LAST) begin
                    tbl_n[idx] = CL2947MP_f_in;
                    if (CL2947MP_f_in != EXPECTED[idx])
                        mis_n = mis + 5'd1;
                    cnt_n = '0;
                    idx_n = idx + 4'd1;
                    // Last vector: score the table including this final sample.
                    if (idx == 4'd15) begin
                        state_n = DONE;
                        match_n = (tbl_n == EXPECTED);
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Vector register follows idx only while applying; parked at zero otherwise.
        vec_n = (state_n == APPLY) ? idx_n : 4'b0000;
    end

    assign {CL2947MP_w, CL2947MP_x, CL2947MP_y, CL2947MP_z} = vec_q;
    assign CL2947MP_busy     = (state == APPLY);
    assign CL2947MP_done     = (state == DONE);
    assign CL2947MP_table    = tbl;
    assign CL2947MP_match    = match_q;
    assign CL2947MP_mismatch = mis;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (SETTLE 1 and 2) driven by emulated
// functions defined as 16-bit truth tables, checked cycle by cycle against a reference.
module tb_truth_table_sweeper;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start0, start1;
    logic        w0, x0, y0, z0, busy0, done0, match0;
    logic        w1, x1, y1, z1, busy1, done1, match1;
    logic [15:0] tbl0, tbl1;
    logic [4:0]  mis0, mis1;
    logic [15:0] tt [2];
    logic [3:0]  vec [2];
    logic        f0, f1;

    int n_cmp = 0;
    int n_err = 0;

    assign vec[0] = {w0, x0, y0, z0};
    assign vec[1] = {w1, x1, y1, z1};
    assign f0 = tt[0][vec[0]];
    assign f1 = tt[1][vec[1]];

    truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(16'hF000)) dut0 (
        .CL2947MP_clk(clk), .CL2947MP_reset(rst), .CL2947MP_start(start0), .CL2947MP_f_in(f0),
        .CL2947MP_w(w0), .CL2947MP_x(x0), .CL2947MP_y(y0), .CL2947MP_z(z0),
        .CL2947MP_busy(busy0), .CL2947MP_done(done0), .CL2947MP_table(tbl0),
        .CL2947MP_match(match0), .CL2947MP_mismatch(mis0));

    truth_table_sweeper #(.SETTLE_CYCLES(2), .EXPECTED(16'h0000)) dut1 (
        .CL2947MP_clk(clk), .CL2947MP_reset(rst), .CL2947MP_start(start1), .CL2947MP_f_in(f1),
        .CL2947MP_w(w1), .CL2947MP_x(x1), .CL2947MP_y(y1), .CL2947MP_z(z1),
        .CL2947MP_busy(busy1), .CL2947MP_done(done1), .CL2947MP_table(tbl1),
        .CL2947MP_match(match1), .CL2947MP_mismatch(mis1));

    typedef struct {
        int          d;
        logic [15:0] t;
        logic        m;
        logic [4:0]  mis;
    } vec_t;
    vec_t vt [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_of(input int d);
        return (d == 0) ? 16'hF000 : 16'h0000;
    endfunction

    task automatic set_start(input int d, input logic v);
        if (d == 0) start0 = v; else start1 = v;
    endtask

    task automatic chk_outs(input int d, input string tag, input logic eb, input logic ed,
                            input logic [3:0] ev);
        chk({tag, "_busy"}, (d == 0) ? busy0 : busy1, eb);
        chk({tag, "_done"}, (d == 0) ? done0 : done1, ed);
        chk({tag, "_vec"}, vec[d], ev);
    endtask

    task automatic chk_res(input int d, input string tag, input logic [15:0] et,
                           input logic em, input logic [4:0] emis);
        chk({tag, "_table"}, (d == 0) ? tbl0 : tbl1, et);
        chk({tag, "_match"}, (d == 0) ? match0 : match1, em);
        chk({tag, "_mismatch"}, (d == 0) ? mis0 : mis1, emis);
    endtask

    // Called right after a negedge; start is sampled at the next rising edge (edge 0).
    task automatic run_sweep(input int d, input logic [15:0] t, input logic em,
                             input logic [4:0] emis, input string tag);
        int s;
        s = (d == 0) ? 1 : 2;
        tt[d] = t;
        set_start(d, 1'b1);
        @(negedge clk);
        set_start(d, 1'b0);
        for (int k = 1; k <= 16 * s; k++) begin
            chk_outs(d, tag, 1'b1, 1'b0, 4'((k - 1) / s));
            @(negedge clk);
        end
        chk_outs(d, {tag, "_donecyc"}, 1'b0, 1'b1, 4'd0);
        chk_res(d, {tag, "_donecyc"}, t, em, emis);
        @(negedge clk);
        chk_outs(d, {tag, "_after"}, 1'b0, 1'b0, 4'd0);
        chk_res(d, {tag, "_after"}, t, em, emis);
    endtask

    initial begin
        vt[0] = '{d: 0, t: 16'hF000, m: 1'b1, mis: 5'd0};   // w&x
        vt[1] = '{d: 0, t: 16'h0FFF, m: 1'b0, mis: 5'd16};
        vt[2] = '{d: 0, t: 16'h0000, m: 1'b0, mis: 5'd4};
        vt[3] = '{d: 1, t: 16'h0000, m: 1'b1, mis: 5'd0};
        vt[4] = '{d: 1, t: 16'hAAAA, m: 1'b0, mis: 5'd8};   // f = z
        vt[5] = '{d: 1, t: 16'hFFFF, m: 1'b0, mis: 5'd16};
        tt[0] = 16'h0000;
        tt[1] = 16'h0000;

        // Reset held two cycles with start high: reset wins.
        rst = 1'b1; start0 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk_outs(d, "reset", 1'b0, 1'b0, 4'd0);
            chk_res(d, "reset", 16'h0000, 1'b0, 5'd0);
        end
        rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
        @(negedge clk);
        chk_outs(0, "post_reset", 1'b0, 1'b0, 4'd0);
        chk_outs(1, "post_reset", 1'b0, 1'b0, 4'd0);

        for (int i = 0; i < 6; i++)
            run_sweep(vt[i].d, vt[i].t, vt[i].m, vt[i].mis, $sformatf("vec%0d", i));

        // Start held high: back-to-back sweeps, one done every 18 cycles.
        tt[0] = 16'hF000;
        start0 = 1'b1;
        for (int c = 1; c <= 54; c++) begin
            @(negedge clk);
            chk("b2b_done", done0, (c % 18) == 17);
            chk("b2b_busy", busy0, ((c % 18) >= 1) && ((c % 18) <= 16));
            if (c == 18) chk("b2b_held_table", tbl0, 16'hF000);
            if (c == 19) chk("b2b_cleared_table", tbl0, 16'h0000);
            if (c == 54) start0 = 1'b0;
        end
        @(negedge clk);
        chk("b2b_stop_busy", busy0, 1'b0);

        // Reset in cycle 5 of a sweep aborts it.
        tt[0] = 16'hFFFF;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (4) @(negedge clk);
        chk_outs(0, "abort_pre", 1'b1, 1'b0, 4'd4);
        chk("abort_pre_table", tbl0, 16'h000F);
        rst = 1'b1;
        @(negedge clk);
        chk_outs(0, "abort_post", 1'b0, 1'b0, 4'd0);
        chk_res(0, "abort_post", 16'h0000, 1'b0, 5'd0);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("abort_no_done", done0, 1'b0);
        end
        run_sweep(0, 16'h5A5A, 1'b0, 5'($countones(16'h5A5A ^ 16'hF000)), "after_abort");

        // Random functions scored by the reference: match iff equal, mismatch = popcount.
        for (int i = 0; i < 8; i++) begin
            int          d;
            logic [15:0] t;
            d = int'($urandom_range(0, 1));
            t = 16'($urandom);
            run_sweep(d, t, t == exp_of(d), 5'($countones(t ^ exp_of(d))),
                      $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
